noc_credit_link_tx: RTL
=======================

Name: noc_credit_link_tx

Overview:
- Transmitter end of the router's credit-based flit link (data/dest/is_tail/send forward, credit backward).
- Takes a valid/ready flit stream from a local source (serializer, traffic generator, pipeline stage) and drives one router input port.
- Never issues more flits than the downstream flit buffer can hold.
- Enforces packet-level dest consistency and reports credit-protocol violations.

Parameters:
- FLIT_WIDTH, 32, flit payload width.
- DEST_WIDTH, 6, routing destination width ({tid, tdest}).
- FLIT_BUFFER_DEPTH, 256, depth of the downstream input buffer; equals the initial credit count.
- CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), width of the credit counter.

Ports:
- clk  in  1  link clock (clk_noc domain).
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  source flit valid.
- in_ready  out  1  flit accepted when in_valid && in_ready.
- in_data  in  FLIT_WIDTH  flit payload.
- in_dest  in  DEST_WIDTH  destination; sampled on head flits only.
- in_is_tail  in  1  last flit of packet.
- data_out  out  FLIT_WIDTH  flit to router input.
- dest_out  out  DEST_WIDTH  flit destination.
- is_tail_out  out  1  tail marker.
- send_out  out  1  one-cycle flit strobe.
- credit_in  in  1  one credit returned per asserted cycle.
- credits_avail  out  CREDIT_WIDTH  current credit count.
- pkt_active  out  1  head accepted, tail not yet accepted.
- err_credit_overflow  out  1  sticky flag: credit returned while counter already full.

Behaviour:
- Reset (rst=1 at posedge):
  - credits_avail=FLIT_BUFFER_DEPTH; send_out=0, data_out=0, dest_out=0, is_tail_out=0; pkt_active=0; err_credit_overflow=0.
  - credit_in is ignored during reset.
  - Reset mid-packet discards packet state; the downstream buffer is reset in the same domain.
- in_ready = !rst && credits_avail != 0. Depends only on registered state, never on in_valid.
- Accept = in_valid && in_ready.
  - Next cycle: send_out=1; data_out=in_data, is_tail_out=in_is_tail, dest_out as below.
  - Latency is exactly 1 cycle.
- No accept: send_out=0 next cycle; data_out, dest_out and is_tail_out hold their last values.
- Dest handling:
  - A head flit is the first accept after reset or after a tail accept.
  - On a head flit, in_dest is captured into dest_hold and driven on dest_out.
  - On body and tail flits, dest_out = dest_hold and in_dest is ignored.
  - A single-flit packet (head with in_is_tail=1) is both head and tail.
- pkt_active is set on a head accept with in_is_tail=0 and cleared on a tail accept.
- Credit counter update: next = credits_avail - accept + credit_in.
  - Simultaneous accept and credit_in: count unchanged.
  - A credit received in cycle t makes in_ready possible in cycle t+1. There is no combinational credit-to-ready path.
- Overflow: credit_in=1, no accept, credits_avail==FLIT_BUFFER_DEPTH → counter saturates and err_credit_overflow is set. The flag clears only on rst.
- Underflow cannot occur, because accept requires credits_avail≠0.
- Throughput: 1 flit/cycle while credits remain; with zero credits, in_ready=0 until a credit returns.

Decomposition:
- noc_link_pkg holds:
  - typedefs flit_t (logic [FLIT_WIDTH-1:0]) and dest_t (logic [DEST_WIDTH-1:0]);
  - a link struct {data, dest, is_tail, send}.
- Sub-module credit_counter (params DEPTH, WIDTH):
  - inputs: consume, restore;
  - outputs: count, nonzero, overflow.
  - It is reused by the router output stage.

Test Plan:
- DEPTH=4, no credit_in, in_valid held high with 6 flits → exactly 4 send_out pulses; in_ready=0 after the 4th accept; credits_avail=0.
- From 0 credits, pulse credit_in once at cycle t → in_ready=1 at t+1; one flit sent; send_out high at t+2; credits back to 0.
- 3-flit packet with in_dest 0x05, 0x2A, 0x11 → dest_out=0x05 on all three flits; is_tail_out=1 only on the third; pkt_active high from accept 1 until the cycle after accept 3.
- DEPTH=4, credits=2, accept and credit_in in the same cycle for 10 cycles → credits_avail stays 2; 10 send_out pulses back-to-back.
- credits=4 (full), credit_in=1, no accept → credits_avail stays 4; err_credit_overflow=1 and stays set until rst.
- rst asserted after a head flit (pkt_active=1, credits=2) → next cycle credits=4, pkt_active=0, send_out=0; the next accept is treated as a head and its dest is captured.

Source files
------------

// File: rtl/noc_link_pkg.sv
// ============================================================================
// Module      : noc_link_pkg
// Description : Shared link types and default widths for the credit-based NoC
//               flit link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_link_pkg;

    localparam int FLIT_WIDTH_DEF        = 32;
    localparam int DEST_WIDTH_DEF        = 6;
    localparam int FLIT_BUFFER_DEPTH_DEF = 256;

    typedef logic [FLIT_WIDTH_DEF-1:0] flit_t;
    typedef logic [DEST_WIDTH_DEF-1:0] dest_t;

    typedef struct packed {
        flit_t data;
        dest_t dest;
        logic  is_tail;
        logic  send;
    } link_t;

endpackage

`default_nettype wire

// File: rtl/credit_counter.sv
// ============================================================================
// Module      : credit_counter
// Description : Saturating credit counter; starts full, one credit consumed or
//               restored per cycle, sticky overflow when restored while full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module credit_counter #(
    parameter int DEPTH = 256,
    parameter int WIDTH = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             consume,
    input  logic             restore,
    output logic [WIDTH-1:0] count,
    output logic             nonzero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] C_FULL = WIDTH'(DEPTH);

    logic [WIDTH-1:0] r_count;
    logic             r_overflow;
    logic             w_take;

    // A consume with no credit left is dropped so the count can never wrap.
    assign w_take = consume && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= C_FULL;
            r_overflow <= 1'b0;
        end else begin
            case ({w_take, restore})
                2'b10:   r_count <= r_count - 1'b1;
                2'b01: begin
                    if (r_count == C_FULL) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: r_count <= r_count;
            endcase
        end
    end

    assign count    = r_count;
    assign nonzero  = (r_count != '0);
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/noc_credit_link_tx.sv
// ============================================================================
// Module      : noc_credit_link_tx
// Description : Transmit side of a credit-based flit link: registers accepted
//               flits toward the router and tracks downstream buffer credits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_credit_link_tx
    import noc_link_pkg::*;
#(
    parameter int FLIT_WIDTH        = FLIT_WIDTH_DEF,
    parameter int DEST_WIDTH        = DEST_WIDTH_DEF,
    parameter int FLIT_BUFFER_DEPTH = FLIT_BUFFER_DEPTH_DEF,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FLIT_WIDTH-1:0]   in_data,
    input  logic [DEST_WIDTH-1:0]   in_dest,
    input  logic                    in_is_tail,
    output logic [FLIT_WIDTH-1:0]   data_out,
    output logic [DEST_WIDTH-1:0]   dest_out,
    output logic                    is_tail_out,
    output logic                    send_out,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credits_avail,
    output logic                    pkt_active,
    output logic                    err_credit_overflow
);

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  is_tail;
        logic                  send;
    } link_reg_t;

    link_reg_t             r_link;
    logic [DEST_WIDTH-1:0] r_dest_hold;
    logic                  r_pkt_active;
    logic                  w_nonzero;
    logic                  w_accept;
    logic [DEST_WIDTH-1:0] w_dest;

    // Ready comes only from registered credit state, so a returning credit
    // becomes usable one cycle later and never races in_valid.
    assign in_ready = !rst && w_nonzero;
    assign w_accept = in_valid && in_ready;

    // Outside a packet the accepted flit is a head and supplies the dest.
    assign w_dest = r_pkt_active ? r_dest_hold : in_dest;

    credit_counter #(
        .DEPTH (FLIT_BUFFER_DEPTH),
        .WIDTH (CREDIT_WIDTH)
    ) u_credit_counter (
        .clk      (clk),
        .rst      (rst),
        .consume  (w_accept),
        .restore  (credit_in),
        .count    (credits_avail),
        .nonzero  (w_nonzero),
        .overflow (err_credit_overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_link       <= '0;
            r_dest_hold  <= '0;
            r_pkt_active <= 1'b0;
        end else begin
            r_link.send <= w_accept;
            if (w_accept) begin
                r_link.data    <= in_data;
                r_link.dest    <= w_dest;
                r_link.is_tail <= in_is_tail;
                r_dest_hold    <= w_dest;
                r_pkt_active   <= !in_is_tail;
            end
        end
    end

    assign data_out    = r_link.data;
    assign dest_out    = r_link.dest;
    assign is_tail_out = r_link.is_tail;
    assign send_out    = r_link.send;
    assign pkt_active  = r_pkt_active;

endmodule

`default_nettype wire
